mems_dac_spi_tx: RTL and testbench
==================================

# mems_dac_spi_tx

DAC-side responder for the MEMS scan arbiter: accepts a per-axis write request (`x_start_flag` / `y_start_flag`) and captures the 16-bit sample from the matching X or Y ROM. It serialises the sample as a 24-bit SPI frame to the dual-channel MEMS-drive DAC, then returns a single-cycle `dac_finish_flag` so the arbiter can advance to the other axis. It sits between the X/Y waveform ROMs and the DAC pins.

## Interface
- `CLK_DIV`, 2: clk cycles per SCLK half-period; legal range 1..255.
- `ROM_LAT`, 1: ROM read latency in clk cycles, counted from the request being sampled; legal range 1..3.
- `SYNC_HIGH`, 2: minimum clk cycles `dac_sync_n` is held high after a frame.
- `DAC_CMD`, 4'b0011: command nibble, "write and update".
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `x_start_flag`  in  1  level request: write X sample; held by the arbiter until `dac_finish_flag`.
- `y_start_flag`  in  1  level request: write Y sample.
- `x_rom_data`  in  16  X ROM read data.
- `y_rom_data`  in  16  Y ROM read data.
- `dac_finish_flag`  out  1  one-cycle pulse: frame complete.
- `busy`  out  1  high from request acceptance through the `dac_finish_flag` cycle.
- `dac_sync_n`  out  1  DAC frame select, active-low.
- `dac_sclk`  out  1  SPI clock; idles low.
- `dac_sdin`  out  1  SPI data, MSB first.

## Operation
- Frame layout, 24 bits: [23:20] `DAC_CMD`, [19:16] channel address, [15:0] ROM data.
  - X uses channel 4'h0; Y uses channel 4'h1.
- States: IDLE, FETCH, SHIFT, SETTLE, DONE, HOLDOFF.
- IDLE: if `x_start_flag` is sampled high, latch axis=X and go to FETCH. Otherwise, if `y_start_flag` is high, latch axis=Y and go to FETCH.
  - If both flags are high, X wins.
  - Request flags are ignored in every state other than IDLE.
- FETCH: lasts ROM_LAT cycles. On the last cycle:
  - capture the selected ROM data into the 24-bit shift register;
  - drive `dac_sync_n`=0 and `dac_sdin`=bit 23;
  - go to SHIFT.
- SHIFT: 24 SCLK periods, each 2·CLK_DIV clk cycles.
  - `dac_sclk` rises after CLK_DIV cycles; the DAC samples on this edge.
  - `dac_sclk` falls CLK_DIV cycles later; the register shifts left and `dac_sdin` takes the next bit on the falling edge.
  - After the 24th falling edge: `dac_sync_n`=1, `dac_sdin`=0, go to SETTLE.
- SETTLE: lasts SYNC_HIGH cycles, then go to DONE.
- DONE: `dac_finish_flag`=1 for one cycle, then go to HOLDOFF.
- HOLDOFF: one cycle, then IDLE. This lets the arbiter's registered flags change, so a still-high old request is never re-accepted.
- Flags dropping mid-frame (arbiter abort, 8'hC3): the frame still completes and `dac_finish_flag` still pulses. A DAC frame is never truncated.
- SCLK divider counter: $clog2(CLK_DIV+1) bits, reloaded at each edge. Bit counter: 5 bits, terminal count 23.

## Timing
- Reset values: `dac_sync_n`=1, `dac_sclk`=0, `dac_sdin`=0, `dac_finish_flag`=0, `busy`=0, state=IDLE, shift register=0.
- Reset asserted mid-frame: all outputs take their reset values immediately (asynchronously).
  - The partial frame is discarded; the DAC ignores it because SYNC rises early.
- Let edge 0 be the edge at which a request is sampled in IDLE.
  - `busy` rises at edge 1.
  - `dac_sync_n` falls at edge ROM_LAT.
  - `dac_finish_flag` is high for the cycle following edge N = ROM_LAT + 48·CLK_DIV + SYNC_HIGH.
  - With defaults, N = 99.
- The next request is sampled no earlier than edge N+2, so back-to-back period = N+2 = 101 clk cycles with defaults.
- `dac_sdin` changes only while `dac_sclk` is low. It is stable at least CLK_DIV clk cycles around each rising edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `mems_dac_pkg`:
  - state enum;
  - FRAME_W=24;
  - channel address constants CH_X=4'h0, CH_Y=4'h1;
  - default DAC_CMD.
- Sub-module `spi_shift_tx`: SCLK divider, 24-bit shift register, bit counter.
  - Inputs: `load` and `frame[23:0]`.
  - Outputs: `sclk`, `sdin`, `done` (pulse on the last falling edge).
- Parent module: request FSM, ROM mux, SYNC, and finish logic.

## Test plan
- Reset, then a single `x_start_flag` with `x_rom_data`=16'hA55A.
  - Capture on the SCLK rising edge must be 24'h30A55A.
  - `dac_finish_flag` must be one pulse at edge 99.
  - `busy` must be low at edge 101.
- `y_start_flag` with `y_rom_data`=16'h0001 must produce frame 24'h310001.
  - `dac_sync_n` must be low for exactly 96 clk cycles.
- Both flags high in the same cycle must produce an X frame.
  - Then, with y still high and x low, the next frame must be Y, sampled at edge 101.
- Emulate the arbiter: hold the flag until finish and toggle axes.
  - Exactly one frame per finish; no duplicate frame from the stale flag level.
- Drop `x_start_flag` at bit 10 of the frame.
  - All 24 bits must still be sent and `dac_finish_flag` must still pulse.
- Assert `rst_n` low at bit 12.
  - Immediately `dac_sync_n`=1, `dac_sclk`=0, `busy`=0.
  - After release, a new request produces a clean full frame.

Source files
------------

// File: rtl/mems_dac_pkg.sv
// Shared constants and types for the MEMS DAC SPI transmitter.
package mems_dac_pkg;

    localparam int         FRAME_W     = 24;
    localparam logic [3:0] CH_X        = 4'h0;
    localparam logic [3:0] CH_Y        = 4'h1;
    localparam logic [3:0] DAC_CMD_DEF = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_DONE    = 3'd4,
        ST_HOLDOFF = 3'd5
    } state_e;

    function automatic logic [FRAME_W-1:0] mk_frame(input logic [3:0]  cmd,
                                                    input logic        axis_y,
                                                    input logic [15:0] data);
        return {cmd, (axis_y ? CH_Y : CH_X), data};
    endfunction

endpackage

// File: rtl/mems_dac_spi_tx_shift.sv
// SPI serialiser: SCLK divider, 24-bit MSB-first shift register and bit counter.
module spi_shift_tx
    import mems_dac_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [FRAME_W-1:0] frame_i,
    output logic               sclk_o,
    output logic               sdin_o,
    output logic               done_o
);

    localparam int             DW      = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0]  DIV_RLD = DW'(CLK_DIV - 1);

    logic [DW-1:0]      div_q;
    logic [4:0]         bit_q;
    logic [FRAME_W-1:0] sr_q;
    logic               sclk_q;
    logic               act_q;
    logic               tick;

    assign tick   = act_q && (div_q == '0);
    // Combinational so the parent can raise SYNC on the very edge SCLK falls.
    assign done_o = tick && sclk_q && (bit_q == 5'd23);
    assign sclk_o = sclk_q;
    assign sdin_o = sr_q[FRAME_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            bit_q  <= '0;
            sr_q   <= '0;
            sclk_q <= 1'b0;
            act_q  <= 1'b0;
        end else if (load_i) begin
            div_q  <= DIV_RLD;
            bit_q  <= '0;
            sr_q   <= frame_i;
            sclk_q <= 1'b0;
            act_q  <= 1'b1;
        end else if (act_q) begin
            if (tick) begin
                div_q  <= DIV_RLD;
                sclk_q <= ~sclk_q;
                if (sclk_q) begin
                    // The 24th shift empties the register, leaving sdin low.
                    sr_q <= {sr_q[FRAME_W-2:0], 1'b0};
                    if (bit_q == 5'd23) act_q <= 1'b0;
                    else                bit_q <= bit_q + 5'd1;
                end
            end else begin
                div_q <= div_q - DW'(1);
            end
        end
    end

endmodule

// File: rtl/mems_dac_spi_tx.sv
// Request FSM, ROM mux, SYNC and finish handshake for the MEMS drive DAC.
module mems_dac_spi_tx
    import mems_dac_pkg::*;
#(
    parameter int         CLK_DIV   = 2,
    parameter int         ROM_LAT   = 1,
    parameter int         SYNC_HIGH = 2,
    parameter logic [3:0] DAC_CMD   = DAC_CMD_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        x_start_flag,
    input  logic        y_start_flag,
    input  logic [15:0] x_rom_data,
    input  logic [15:0] y_rom_data,
    output logic        dac_finish_flag,
    output logic        busy,
    output logic        dac_sync_n,
    output logic        dac_sclk,
    output logic        dac_sdin
);

    localparam logic [1:0] FETCH_LAST  = 2'(ROM_LAT - 1);
    localparam logic [7:0] SETTLE_LAST = (SYNC_HIGH > 1) ? 8'(SYNC_HIGH - 2) : 8'd0;

    state_e     state_q, state_d;
    logic       axis_q, axis_d;
    logic [1:0] fcnt_q, fcnt_d;
    logic [7:0] scnt_q, scnt_d;
    logic       sync_n_q, busy_q, finish_q;
    logic       load, shift_done;

    always_comb begin
        state_d = state_q;
        axis_d  = axis_q;
        fcnt_d  = fcnt_q;
        scnt_d  = scnt_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (x_start_flag) begin
                    state_d = ST_FETCH;
                    axis_d  = 1'b0;
                    fcnt_d  = '0;
                end else if (y_start_flag) begin
                    state_d = ST_FETCH;
                    axis_d  = 1'b1;
                    fcnt_d  = '0;
                end
            end
            ST_FETCH: begin
                if (fcnt_q == FETCH_LAST) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    fcnt_d = fcnt_q + 2'd1;
                end
            end
            ST_SHIFT: begin
                // SYNC is already high through SETTLE and DONE, so SETTLE covers one cycle less.
                if (shift_done) begin
                    state_d = (SYNC_HIGH > 1) ? ST_SETTLE : ST_DONE;
                    scnt_d  = '0;
                end
            end
            ST_SETTLE: begin
                if (scnt_q == SETTLE_LAST) state_d = ST_DONE;
                else                       scnt_d  = scnt_q + 8'd1;
            end
            ST_DONE:    state_d = ST_HOLDOFF;
            ST_HOLDOFF: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            axis_q   <= 1'b0;
            fcnt_q   <= '0;
            scnt_q   <= '0;
            sync_n_q <= 1'b1;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            axis_q   <= axis_d;
            fcnt_q   <= fcnt_d;
            scnt_q   <= scnt_d;
            if (load)            sync_n_q <= 1'b0;
            else if (shift_done) sync_n_q <= 1'b1;
            // Status flags trail the state by one cycle, which places the finish pulse in HOLDOFF.
            busy_q   <= (state_q != ST_IDLE);
            finish_q <= (state_q == ST_DONE);
        end
    end

    spi_shift_tx #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .frame_i (mk_frame(DAC_CMD, axis_q, axis_q ? y_rom_data : x_rom_data)),
        .sclk_o  (dac_sclk),
        .sdin_o  (dac_sdin),
        .done_o  (shift_done)
    );

    assign dac_sync_n      = sync_n_q;
    assign busy            = busy_q;
    assign dac_finish_flag = finish_q;

endmodule

// File: tb/tb_mems_dac_spi_tx.sv
// Directed bench for mems_dac_spi_tx at default parameters (finish at edge 99, period 101).
module tb_mems_dac_spi_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        x_start_flag = 1'b0;
    logic        y_start_flag = 1'b0;
    logic [15:0] x_rom_data = '0;
    logic [15:0] y_rom_data = '0;
    logic        dac_finish_flag, busy, dac_sync_n, dac_sclk, dac_sdin;

    int checks = 0;
    int errors = 0;

    logic [23:0] cap_sr = '0;
    int          cap_n = 0, sync_lo = 0, fin_n = 0;

    mems_dac_spi_tx dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .x_start_flag    (x_start_flag),
        .y_start_flag    (y_start_flag),
        .x_rom_data      (x_rom_data),
        .y_rom_data      (y_rom_data),
        .dac_finish_flag (dac_finish_flag),
        .busy            (busy),
        .dac_sync_n      (dac_sync_n),
        .dac_sclk        (dac_sclk),
        .dac_sdin        (dac_sdin)
    );

    always #5 clk = ~clk;

    // DAC model: samples data on every SCLK rise.
    always @(posedge dac_sclk) begin
        cap_sr = {cap_sr[22:0], dac_sdin};
        cap_n++;
    end

    always @(posedge clk) begin
        if (!dac_sync_n)     sync_lo++;
        if (dac_finish_flag) fin_n++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Returns #1 after edge 0, the edge that samples the request.
    task automatic req(input logic x, input logic y);
        @(negedge clk);
        x_start_flag = x;
        y_start_flag = y;
        @(posedge clk);
        #1;
    endtask

    // Called #1 after edge `start`; ends #1 after the edge following the finish edge + 1.
    task automatic finish_frame(input string tag, input int start, input int exp_edge,
                                input logic [23:0] exp_frame, input int n0, input int f0,
                                input logic hold_y);
        int e;
        e = 0;
        for (int i = start + 1; i <= start + 400; i++) begin
            @(posedge clk);
            #1;
            if (dac_finish_flag) begin
                e = i;
                break;
            end
        end
        chk({tag, "_fin_edge"}, 32'(e), 32'(exp_edge));
        chk({tag, "_frame"}, {8'h0, cap_sr}, {8'h0, exp_frame});
        chk({tag, "_nbits"}, 32'(cap_n - n0), 32'd24);
        @(posedge clk);
        #1;
        chk({tag, "_fin_pulse"}, {31'h0, dac_finish_flag}, 32'd0);
        chk({tag, "_fin_cnt"}, 32'(fin_n - f0), 32'd1);
        x_start_flag = 1'b0;
        if (!hold_y) y_start_flag = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_busy_low"}, {31'h0, busy}, 32'd0);
    endtask

    initial begin
        int n0, f0, s0, ed;
        logic reached;

        // Reset state
        #12;
        chk("rst_outs", {27'h0, dac_sync_n, dac_sclk, dac_sdin, dac_finish_flag, busy}, 32'b10000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single X frame
        x_rom_data = 16'hA55A;
        n0 = cap_n; f0 = fin_n; s0 = sync_lo;
        req(1'b1, 1'b0);
        @(posedge clk); #1;
        chk("t1_edge1", {30'h0, busy, dac_sync_n}, 32'b10);
        finish_frame("t1", 1, 99, 24'h30A55A, n0, f0, 1'b0);
        chk("t1_sync_low", 32'(sync_lo - s0), 32'd96);

        // Single Y frame
        y_rom_data = 16'h0001;
        n0 = cap_n; f0 = fin_n; s0 = sync_lo;
        req(1'b0, 1'b1);
        finish_frame("t2", 0, 99, 24'h310001, n0, f0, 1'b0);
        chk("t2_sync_low", 32'(sync_lo - s0), 32'd96);

        // Both flags: X wins, then Y is sampled at edge 101
        x_rom_data = 16'h1234;
        y_rom_data = 16'hBEEF;
        n0 = cap_n; f0 = fin_n;
        req(1'b1, 1'b1);
        finish_frame("t3x", 0, 99, 24'h301234, n0, f0, 1'b1);
        n0 = cap_n; f0 = fin_n;
        @(posedge clk); #1;
        chk("t3_y_edge102", {30'h0, busy, dac_sync_n}, 32'b10);
        finish_frame("t3y", 102, 200, 24'h31BEEF, n0, f0, 1'b0);

        // Arbiter emulation: alternate axes, one frame per finish
        for (int k = 0; k < 4; k++) begin
            x_rom_data = 16'h1111 * 16'(k + 1);
            y_rom_data = 16'h0F0F ^ 16'(k);
            n0 = cap_n; f0 = fin_n;
            req(!k[0], k[0]);
            finish_frame("t4", 0, 99,
                         k[0] ? {8'h31, 16'h0F0F ^ 16'(k)} : {8'h30, 16'h1111 * 16'(k + 1)},
                         n0, f0, 1'b0);
        end
        n0 = cap_n;
        repeat (20) @(posedge clk);
        #1;
        chk("t4_no_dup", {31'h0, busy}, 32'd0);
        chk("t4_no_bits", 32'(cap_n - n0), 32'd0);

        // Flag dropped at bit 10: frame still completes
        x_rom_data = 16'h0F0F;
        n0 = cap_n; f0 = fin_n;
        req(1'b1, 1'b0);
        ed = 0;
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            ed++;
            if (cap_n - n0 >= 10) begin
                reached = 1'b1;
                break;
            end
        end
        chk("t5_reach10", {31'h0, reached}, 32'd1);
        x_start_flag = 1'b0;
        finish_frame("t5", ed, 99, 24'h300F0F, n0, f0, 1'b0);

        // Reset mid-frame at bit 12
        y_rom_data = 16'h5555;
        n0 = cap_n;
        req(1'b0, 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (cap_n - n0 >= 12) begin
                reached = 1'b1;
                break;
            end
        end
        chk("t6_reach12", {31'h0, reached}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_outs", {27'h0, dac_sync_n, dac_sclk, busy, dac_sdin, dac_finish_flag}, 32'b10000);
        y_start_flag = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        x_rom_data = 16'hC3C3;
        n0 = cap_n; f0 = fin_n;
        req(1'b1, 1'b0);
        finish_frame("t6", 0, 99, 24'h30C3C3, n0, f0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
